highlight_overlay: RTL and testbench

HIGHLIGHT_OVERLAY -- requirements
Module: highlight_overlay

---
 rtl/highlight_overlay.sv | 61 ++++++
 tb/tb_highlight_overlay.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/highlight_overlay.sv
// Highlight overlay: merges the subtract-stage mask with the original image,
// replacing masked pixels with a fixed colour and counting pixels per frame.
module highlight_overlay #(
  parameter int          WIDTH           = 720,
  parameter int          HEIGHT          = 540,
  parameter logic [23:0] HIGHLIGHT_COLOR = 24'h0000FF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mask_empty,
  input  logic [7:0]  mask_dout,
  output logic        mask_rd_en,
  input  logic        img_empty,
  input  logic [23:0] img_dout,
  output logic        img_rd_en,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [23:0] out_din,
  output logic        frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]    state;
  logic [23:0]   pix;
  logic [CW-1:0] cnt;
  logic          pop;

  // Outputs are gated by reset so they drop the instant reset asserts.
  assign pop = reset && (state == S_FETCH)
             && !mask_empty && !img_empty;

  assign mask_rd_en = pop;
  assign img_rd_en  = pop;
  assign out_wr_en  = reset && (state == S_WRITE) && !out_full;
  assign frame_done = out_wr_en && (cnt == LAST);
  assign out_din    = pix;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pix   <= 24'h000000;
      cnt   <= '0;
    end else begin
      if (pop) begin
        pix   <= (mask_dout != 8'h00) ? HIGHLIGHT_COLOR : img_dout;
        state <= S_WRITE;
      end
      if (out_wr_en) begin
        state <= S_FETCH;
        cnt   <= frame_done ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_highlight_overlay.sv
// Directed bench for highlight_overlay on a 4x2 frame.
module tb_highlight_overlay;

  logic        clock;
  logic        reset;
  logic        mask_empty;
  logic [7:0]  mask_dout;
  logic        mask_rd_en;
  logic        img_empty;
  logic [23:0] img_dout;
  logic        img_rd_en;
  logic        out_full;
  logic        out_wr_en;
  logic [23:0] out_din;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_idx   = 0;

  highlight_overlay #(
    .WIDTH(4),
    .HEIGHT(2),
    .HIGHLIGHT_COLOR(24'h0000FF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mask_empty(mask_empty),
    .mask_dout(mask_dout),
    .mask_rd_en(mask_rd_en),
    .img_empty(img_empty),
    .img_dout(img_dout),
    .img_rd_en(img_rd_en),
    .out_full(out_full),
    .out_wr_en(out_wr_en),
    .out_din(out_din),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  mask;
    logic [23:0] img;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One pop cycle then one write cycle; frame_done follows the model count.
  task automatic push(input logic [7:0] m,
                      input logic [23:0] p,
                      input logic [23:0] e);
    mask_dout  = m;
    img_dout   = p;
    mask_empty = 1'b0;
    img_empty  = 1'b0;
    #1;
    check("pop_mask", 32'(mask_rd_en), 32'd1);
    check("pop_img", 32'(img_rd_en), 32'd1);
    check("no_wr_in_fetch", 32'(out_wr_en), 32'd0);
    @(posedge clock);
    #1;
    mask_empty = 1'b1;
    img_empty  = 1'b1;
    #1;
    check("wr_en", 32'(out_wr_en), 32'd1);
    check("pixel", 32'(out_din), 32'(e));
    check("frame_done", 32'(frame_done), (wr_idx % 8 == 7) ? 32'd1 : 32'd0);
    wr_idx++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h00, 24'h123456, 24'h123456};
    vecs[1] = '{8'hFF, 24'hABCDEF, 24'h0000FF};
    vecs[2] = '{8'h01, 24'hABCDEF, 24'h0000FF};
    vecs[3] = '{8'h00, 24'h000000, 24'h000000};
    vecs[4] = '{8'h80, 24'hFFFFFF, 24'h0000FF};
    vecs[5] = '{8'h00, 24'hFFFFFF, 24'hFFFFFF};
    vecs[6] = '{8'h10, 24'h00FF00, 24'h0000FF};
    vecs[7] = '{8'h00, 24'hA5A5A5, 24'hA5A5A5};

    reset      = 1'b0;
    mask_empty = 1'b0;
    img_empty  = 1'b0;
    mask_dout  = 8'hFF;
    img_dout   = 24'h111111;
    out_full   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mask_rd", 32'(mask_rd_en), 32'd0);
    check("rst_img_rd", 32'(img_rd_en), 32'd0);
    check("rst_wr", 32'(out_wr_en), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_din", 32'(out_din), 32'd0);
    mask_empty = 1'b1;
    img_empty  = 1'b1;
    reset      = 1'b1;
    @(posedge clock);
    #1;

    // Table vectors: exactly one frame of 8 pixels.
    for (int i = 0; i < 8; i++)
      push(vecs[i].mask, vecs[i].img, vecs[i].exp);

    // Image FIFO empty while mask holds data: nothing may move.
    mask_empty = 1'b0;
    mask_dout  = 8'hFF;
    img_empty  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("img_empty_mask_rd", 32'(mask_rd_en), 32'd0);
      check("img_empty_wr", 32'(out_wr_en), 32'd0);
      @(posedge clock);
      #1;
    end
    mask_empty = 1'b1;

    // Output back-pressure for 5 cycles with both FIFOs still non-empty.
    mask_dout  = 8'h00;
    img_dout   = 24'h345678;
    mask_empty = 1'b0;
    img_empty  = 1'b0;
    #1;
    check("bp_pop", 32'(img_rd_en), 32'd1);
    @(posedge clock);
    #1;
    out_full  = 1'b1;
    img_dout  = 24'h999999;
    mask_dout = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_wr", 32'(out_wr_en), 32'd0);
      check("bp_mask_rd", 32'(mask_rd_en), 32'd0);
      check("bp_img_rd", 32'(img_rd_en), 32'd0);
      check("bp_din", 32'(out_din), 32'h00345678);
      @(posedge clock);
      #1;
    end
    mask_empty = 1'b1;
    img_empty  = 1'b1;
    out_full   = 1'b0;
    #1;
    check("bp_release_wr", 32'(out_wr_en), 32'd1);
    check("bp_release_din", 32'(out_din), 32'h00345678);
    check("bp_release_fd", 32'(frame_done), 32'd0);
    wr_idx++;
    @(posedge clock);
    #1;
    check("bp_single_wr", 32'(out_wr_en), 32'd0);

    // Fresh start, then two full frames back to back.
    reset = 1'b0;
    #2;
    reset  = 1'b1;
    wr_idx = 0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++)
      push(8'(i), 24'h00A000 + 24'(i), (i == 0) ? 24'h00A000 : 24'h0000FF);

    // Reset between a pop and its write discards the pixel and count.
    for (int i = 0; i < 3; i++)
      push(8'h00, 24'h0C0C0C, 24'h0C0C0C);
    mask_dout  = 8'h00;
    img_dout   = 24'h777777;
    mask_empty = 1'b0;
    img_empty  = 1'b0;
    @(posedge clock);
    #1;
    mask_empty = 1'b1;
    img_empty  = 1'b1;
    reset      = 1'b0;
    #1;
    check("midrst_wr", 32'(out_wr_en), 32'd0);
    check("midrst_cnt", 32'(dut.cnt), 32'd0);
    check("midrst_din", 32'(out_din), 32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    wr_idx = 0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++)
      push(8'h00, 24'h0000AA + 24'(i), 24'h0000AA + 24'(i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
